booth_seq_ctrl: RTL

//   Sequencing FSM for the radix-2 Booth multiplier datapath (load/add/sub/shift

---
 rtl/booth_seq_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_ctrl
//  Function : Moore sequencing FSM for a radix-2 Booth multiplier datapath.
//             It loads the operands, runs WIDTH Booth iterations, waits one
//             settle cycle for the result register, then pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module booth_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         q0,
  input  logic                         qn1,
  output logic                         load,
  output logic                         add_en,
  output logic                         sub_en,
  output logic                         shift_en,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   iter
);

  localparam int                  c_iter_w    = $clog2(WIDTH + 1);
  localparam logic [c_iter_w-1:0] c_last_iter = c_iter_w'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EVAL   = 3'd2,
    S_ADD    = 3'd3,
    S_SUB    = 3'd4,
    S_SHIFT  = 3'd5,
    S_SETTLE = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_iter_w-1:0] r_iter;
  logic                w_in_flight;

  assign w_in_flight = (r_state == S_LOAD)  || (r_state == S_EVAL)  ||
                       (r_state == S_ADD)   || (r_state == S_SUB)   ||
                       (r_state == S_SHIFT) || (r_state == S_SETTLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The shift aborted in flight does not count as a completed shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter <= '0;
    end else if (r_state == S_LOAD) begin
      r_iter <= '0;
    end else if ((r_state == S_SHIFT) && !abort) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    if (w_in_flight && abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = start ? S_LOAD : S_IDLE;
        S_LOAD:   w_next = S_EVAL;
        S_EVAL: begin
          case ({q0, qn1})
            2'b10:   w_next = S_SUB;
            2'b01:   w_next = S_ADD;
            default: w_next = S_SHIFT;
          endcase
        end
        S_ADD:    w_next = S_SHIFT;
        S_SUB:    w_next = S_SHIFT;
        S_SHIFT:  w_next = (r_iter == c_last_iter) ? S_SETTLE : S_EVAL;
        S_SETTLE: w_next = S_DONE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Outputs depend on the registered state only.
  always_comb begin
    load     = 1'b0;
    add_en   = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_LOAD:   begin load     = 1'b1; busy = 1'b1; end
      S_EVAL:   begin                  busy = 1'b1; end
      S_ADD:    begin add_en   = 1'b1; busy = 1'b1; end
      S_SUB:    begin sub_en   = 1'b1; busy = 1'b1; end
      S_SHIFT:  begin shift_en = 1'b1; busy = 1'b1; end
      S_SETTLE: begin                  busy = 1'b1; end
      S_DONE:   begin done     = 1'b1;              end
      default:  begin                               end
    endcase
  end

  assign iter = r_iter;

endmodule
`default_nettype wire
